// File: rtl/crypto_seq_pkg.sv
// Shared state encoding, default widths and helpers for the ECC/3DES sequencer.
package crypto_seq_pkg;

  localparam int unsigned ECC_W_DEF = 163;
  localparam int unsigned KEY_W_DEF = 192;

  typedef enum logic [3:0] {
    IDLE,
    ECC_PUB,
    ECC_SHR,
    PUB_DONE,
    SHR_DONE,
    KEY_LOAD,
    DES_INIT,
    DES_DATA,
    DES_DRAIN
  } state_e;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/crypto_key_pack.sv
// Packs ECC result slices into the 3DES session key bundle (combinational).
module crypto_key_pack
  import crypto_seq_pkg::*;
#(
  parameter int unsigned ECC_W = ECC_W_DEF,
  parameter int unsigned KEY_W = KEY_W_DEF
) (
  input  logic [ECC_W-2:0]     x_lo,
  input  logic [KEY_W-ECC_W:0] y_lo,
  output logic [KEY_W-1:0]     key_c
);

  assign key_c = {y_lo, x_lo};

endmodule

// File: rtl/crypto_seq_ctrl.sv
// Sequencer for the ECC point-multiply core and the timed 3DES session phases.
// Optional ECC wait timeout is enabled by defining CRYPTO_SEQ_ECC_TIMEOUT_EN.
module crypto_seq_ctrl
  import crypto_seq_pkg::*;
#(
  parameter int unsigned ECC_W         = ECC_W_DEF,
  parameter int unsigned KEY_W         = KEY_W_DEF,
  parameter int unsigned KEY_WAIT_CYC  = 2,
  parameter int unsigned DES_INIT_CYC  = 48,
  parameter int unsigned DATA_PERIOD   = 2,
  parameter int unsigned DES_DRAIN_CYC = 48,
  parameter int unsigned ECC_TIMEOUT   = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ecc_start_pub,
  input  logic             ecc_start_shr,
  input  logic             des_start,
  output logic             ecc_go,
  input  logic [ECC_W-1:0] ecc_x,
  input  logic [ECC_W-1:0] ecc_y,
  input  logic             ecc_done,
  output logic [ECC_W-1:0] pub_x,
  output logic [ECC_W-1:0] pub_y,
  output logic [KEY_W-1:0] session_key,
  output logic             key_valid,
  output logic             pub_done,
  output logic             shr_done,
  output logic             des_strobe,
  output logic             des_done,
  output logic             err
);

  localparam int unsigned CNT_W =
    $clog2(max4(KEY_WAIT_CYC, DES_INIT_CYC, DATA_PERIOD, DES_DRAIN_CYC)) + 1;

  if (KEY_W < ECC_W || KEY_W > 2*ECC_W - 1 || KEY_WAIT_CYC == 0 || DES_INIT_CYC == 0 ||
      DATA_PERIOD == 0 || DES_DRAIN_CYC == 0 || ECC_TIMEOUT == 0) begin : g_bad_cfg
    $error("crypto_seq_ctrl: illegal parameter set");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ECC_W-1:0] pub_x_q, pub_x_d, pub_y_q, pub_y_d;
  logic [KEY_W-1:0] key_q, key_d, key_c;
  logic             key_valid_q, key_valid_d;
  logic             ecc_go_c, pub_done_c, shr_done_c, des_strobe_c, des_done_c, err_c;

`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(ECC_TIMEOUT) + 1;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_err_q, tmo_err_d;
`endif

  crypto_key_pack #(
    .ECC_W (ECC_W),
    .KEY_W (KEY_W)
  ) u_key_pack (
    .x_lo  (ecc_x[ECC_W-2:0]),
    .y_lo  (ecc_y[KEY_W-ECC_W:0]),
    .key_c (key_c)
  );

  // Next-state, capture and per-state output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    pub_x_d      = pub_x_q;
    pub_y_d      = pub_y_q;
    key_d        = key_q;
    key_valid_d  = key_valid_q;
    ecc_go_c     = 1'b0;
    pub_done_c   = 1'b0;
    shr_done_c   = 1'b0;
    des_strobe_c = 1'b0;
    des_done_c   = 1'b0;
    err_c        = 1'b0;
`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
    tmo_d        = '0;
    tmo_err_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (ecc_start_pub)      state_d = ECC_PUB;
        else if (ecc_start_shr) state_d = ECC_SHR;
        else if (des_start) begin
          if (key_valid_q) state_d = KEY_LOAD;
          else             err_c   = 1'b1;
        end
      end
      ECC_PUB, ECC_SHR: begin
        ecc_go_c = 1'b1;
`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
        tmo_d = tmo_q + TMO_W'(1);
`endif
        if (ecc_done) begin
          if (state_q == ECC_PUB) begin
            pub_x_d = ecc_x;
            pub_y_d = ecc_y;
            state_d = PUB_DONE;
          end else begin
            key_d       = key_c;
            key_valid_d = 1'b1;
            state_d     = SHR_DONE;
          end
        end
`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
        else if (tmo_q == TMO_W'(ECC_TIMEOUT - 1)) begin
          state_d   = IDLE;
          tmo_err_d = 1'b1;
        end
`endif
      end
      PUB_DONE: begin
        pub_done_c = 1'b1;
        state_d    = IDLE;
      end
      SHR_DONE: begin
        shr_done_c = 1'b1;
        state_d    = IDLE;
      end
      KEY_LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(KEY_WAIT_CYC - 1)) state_d = DES_INIT;
      end
      DES_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DES_INIT_CYC - 1)) state_d = DES_DATA;
      end
      DES_DATA: begin
        // Counter tracks strobe phase; a strobe fires whenever it is at zero.
        if (!des_start) begin
          state_d = DES_DRAIN;
        end else begin
          des_strobe_c = (cnt_q == '0);
          cnt_d = (cnt_q == CNT_W'(DATA_PERIOD - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
      end
      DES_DRAIN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DES_DRAIN_CYC - 1)) begin
          des_done_c = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pub_x_q     <= '0;
      pub_y_q     <= '0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pub_x_q     <= pub_x_d;
      pub_y_q     <= pub_y_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
    end
  end

`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign err = err_c | tmo_err_q;
`else
  assign err = err_c;
`endif

  assign ecc_go      = ecc_go_c;
  assign pub_done    = pub_done_c;
  assign shr_done    = shr_done_c;
  assign des_strobe  = des_strobe_c;
  assign des_done    = des_done_c;
  assign pub_x       = pub_x_q;
  assign pub_y       = pub_y_q;
  assign session_key = key_q;
  assign key_valid   = key_valid_q;

endmodule

// File: tb/tb_crypto_seq_ctrl.sv
// Self-checking bench for crypto_seq_ctrl: vector table, directed sequences, random ops.
`timescale 1ns/1ps
module tb_crypto_seq_ctrl;

  localparam int EW    = 163;
  localparam int KW    = 192;
  localparam int KWAIT = 2;
  localparam int INIT  = 48;
  localparam int PER   = 2;
  localparam int DRAIN = 48;
`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
  localparam int TMO     = 16;
  localparam int MAX_LAT = 16;
`else
  localparam int TMO     = 1048576;
  localparam int MAX_LAT = 12;
`endif

  logic          clk, rst;
  logic          ecc_start_pub, ecc_start_shr, des_start, ecc_done;
  logic [EW-1:0] ecc_x, ecc_y, pub_x, pub_y;
  logic [KW-1:0] session_key;
  logic          ecc_go, key_valid, pub_done, shr_done, des_strobe, des_done, err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [EW-1:0] m_px, m_py;
  logic [KW-1:0] m_key;
  logic          m_kv;

  typedef struct {
    bit            shr;
    int            lat;
    logic [EW-1:0] x, y, px, py;
    logic [KW-1:0] key;
    bit            kv;
  } vec_t;
  vec_t tbl[5];

  crypto_seq_ctrl #(
    .ECC_W(EW), .KEY_W(KW), .KEY_WAIT_CYC(KWAIT), .DES_INIT_CYC(INIT),
    .DATA_PERIOD(PER), .DES_DRAIN_CYC(DRAIN), .ECC_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .ecc_start_pub(ecc_start_pub), .ecc_start_shr(ecc_start_shr),
    .des_start(des_start), .ecc_go(ecc_go), .ecc_x(ecc_x), .ecc_y(ecc_y), .ecc_done(ecc_done),
    .pub_x(pub_x), .pub_y(pub_y), .session_key(session_key), .key_valid(key_valid),
    .pub_done(pub_done), .shr_done(shr_done), .des_strobe(des_strobe), .des_done(des_done),
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [5:0] outs();
    return {ecc_go, pub_done, shr_done, des_strobe, des_done, err};
  endfunction

  // Key bundle by arithmetic: low ECC_W-1 bits of x, y shifted above them, truncated.
  function automatic logic [KW-1:0] model_key(input logic [EW-1:0] x, input logic [EW-1:0] y);
    logic [EW+KW-1:0] wx, wy, one;
    one = 1;
    wx  = {{KW{1'b0}}, x} & ((one << (EW - 1)) - one);
    wy  = {{KW{1'b0}}, y} << (EW - 1);
    return KW'(wx | wy);
  endfunction

  function automatic logic [EW-1:0] rnd_w();
    logic [191:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[EW-1:0];
  endfunction

  function automatic vec_t mk(input bit shr, input int lat, input logic [EW-1:0] x,
                              input logic [EW-1:0] y, input logic [EW-1:0] px,
                              input logic [EW-1:0] py, input logic [KW-1:0] key, input bit kv);
    vec_t v;
    v.shr = shr; v.lat = lat; v.x = x; v.y = y; v.px = px; v.py = py; v.key = key; v.kv = kv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", name, $time, act, exp);
    end
  endtask

  // Output vector order: ecc_go, pub_done, shr_done, des_strobe, des_done, err.
  task automatic chk_o(input string name, input logic [5:0] exp);
    chk(name, 256'(outs()), 256'(exp));
  endtask

  task automatic chk_regs(input string name);
    chk({name, "_pub_x"}, 256'(pub_x), 256'(m_px));
    chk({name, "_pub_y"}, 256'(pub_y), 256'(m_py));
    chk({name, "_key"}, 256'(session_key), 256'(m_key));
    chk({name, "_kv"}, 256'(key_valid), 256'(m_kv));
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic rnd_starts();
    ecc_start_pub = 1'($urandom_range(0, 1));
    ecc_start_shr = 1'($urandom_range(0, 1));
    des_start     = 1'($urandom_range(0, 1));
  endtask

  task automatic run_ecc(input bit shr, input int lat, input logic [EW-1:0] x,
                         input logic [EW-1:0] y, input bit all3);
    ecc_start_pub = !shr || all3;
    ecc_start_shr = shr || all3;
    des_start     = all3;
    ecc_done      = 1'b0;
    ecc_x = rnd_w(); ecc_y = rnd_w();
    #1 chk_o("ecc_accept", 6'b000000);
    nxt();
    for (int i = 1; i <= lat; i++) begin
      rnd_starts();
      ecc_done = (i == lat);
      ecc_x = (i == lat) ? x : rnd_w();
      ecc_y = (i == lat) ? y : rnd_w();
      #1 chk_o("ecc_wait", 6'b100000);
      nxt();
    end
    rnd_starts();
    ecc_done = 1'b0;
    ecc_x = rnd_w(); ecc_y = rnd_w();
    #1 chk_o("ecc_done_pulse", shr ? 6'b001000 : 6'b010000);
    if (shr) begin
      m_key = model_key(x, y);
      m_kv  = 1'b1;
    end else begin
      m_px = x;
      m_py = y;
    end
    chk_regs("ecc");
    nxt();
    ecc_start_pub = 1'b0; ecc_start_shr = 1'b0; des_start = 1'b0;
    ecc_done = 1'($urandom_range(0, 1));
    #1 chk_o("ecc_back_idle", 6'b000000);
    nxt();
    ecc_done = 1'b0;
  endtask

  task automatic run_des(input int hold, input bit noise);
    int d, last, nstb, done_at;
    logic [5:0] e;
    d = KWAIT + INIT + 1;
    last = d + hold + DRAIN;
    nstb = 0;
    done_at = -1;
    for (int c = 0; c <= last + 1; c++) begin
      des_start = (c < d + hold);
      if (noise && c > KWAIT && c < d) des_start = 1'($urandom_range(0, 1));
      if (noise && c > 0 && c <= last) begin
        ecc_start_pub = 1'($urandom_range(0, 1));
        ecc_start_shr = 1'($urandom_range(0, 1));
        ecc_done      = 1'($urandom_range(0, 1));
      end else begin
        ecc_start_pub = 1'b0; ecc_start_shr = 1'b0; ecc_done = 1'b0;
      end
      e = '0;
      e[2] = (c >= d) && (c < d + hold) && (((c - d) % PER) == 0);
      e[1] = (c == last);
      #1 chk_o("des_cycle", e);
      if (des_strobe) nstb++;
      if (des_done) done_at = c;
      nxt();
    end
    chk("des_strobe_count", 256'(nstb), 256'((hold + PER - 1) / PER));
    chk("des_done_after_drop", 256'(done_at - (d + hold)), 256'(DRAIN));
  endtask

  task automatic err_probe(input int n);
    for (int i = 0; i < n; i++) begin
      des_start = 1'b1; ecc_start_pub = 1'b0; ecc_start_shr = 1'b0;
      ecc_done = (i == 0);
      #1 chk_o("err_missing_key", 6'b000001);
      nxt();
    end
    des_start = 1'b0; ecc_done = 1'b0;
    #1 chk_o("err_release", 6'b000000);
    chk_regs("err_probe");
    nxt();
  endtask

`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
  task automatic run_tmo();
    ecc_start_shr = 1'b1; ecc_start_pub = 1'b0; des_start = 1'b0; ecc_done = 1'b0;
    #1 chk_o("tmo_accept", 6'b000000);
    nxt();
    ecc_start_shr = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      ecc_x = rnd_w(); ecc_y = rnd_w();
      #1 chk_o("tmo_wait", 6'b100000);
      nxt();
    end
    #1 chk_o("tmo_err_pulse", 6'b000001);
    chk_regs("tmo");
    nxt();
    #1 chk_o("tmo_after", 6'b000000);
    nxt();
  endtask
`endif

  initial begin
    int op;
    tbl[0] = mk(1'b0, 10, 163'h5A5, 163'h3C3, 163'h5A5, 163'h3C3, '0, 1'b0);
    tbl[1] = mk(1'b1, 3, {EW{1'b1}}, 163'h1FFFFFFF, 163'h5A5, 163'h3C3,
                {1'b0, {191{1'b1}}}, 1'b1);
    tbl[2] = mk(1'b1, 1, 163'h1_2345_6789, 163'h3FFF_FFFF, 163'h5A5, 163'h3C3,
                {30'h3FFF_FFFF, 162'h1_2345_6789}, 1'b1);
    tbl[3] = mk(1'b1, 7, {1'b1, 162'h1}, 163'h7_2AAA_AAAA, 163'h5A5, 163'h3C3,
                {30'h2AAA_AAAA, 162'h1}, 1'b1);
    tbl[4] = mk(1'b0, 5, {EW{1'b1}}, '0, {EW{1'b1}}, '0,
                {30'h2AAA_AAAA, 162'h1}, 1'b1);

    rst = 1'b1;
    ecc_start_pub = 1'b0; ecc_start_shr = 1'b0; des_start = 1'b0; ecc_done = 1'b0;
    ecc_x = '0; ecc_y = '0;
    m_px = '0; m_py = '0; m_key = '0; m_kv = 1'b0;
    @(negedge clk);
    #1 chk_o("reset_outputs", 6'b000000);
    chk_regs("reset");
    @(negedge clk);
    rst = 1'b0;

    err_probe(4);

    for (int i = 0; i < 5; i++) begin
      run_ecc(tbl[i].shr, tbl[i].lat, tbl[i].x, tbl[i].y, 1'b0);
      chk("tbl_pub_x", 256'(pub_x), 256'(tbl[i].px));
      chk("tbl_pub_y", 256'(pub_y), 256'(tbl[i].py));
      chk("tbl_key", 256'(session_key), 256'(tbl[i].key));
      chk("tbl_kv", 256'(key_valid), 256'(tbl[i].kv));
    end

    run_ecc(1'b0, 4, 163'h1234, 163'h5678, 1'b1);

    run_des(60, 1'b0);
    run_des(0, 1'b0);
    run_des(1, 1'b1);
    run_des(5, 1'b1);

`ifdef CRYPTO_SEQ_ECC_TIMEOUT_EN
    run_ecc(1'b1, TMO, rnd_w(), rnd_w(), 1'b0);
    run_tmo();
`endif

    for (int k = 0; k < 24; k++) begin
      op = int'($urandom_range(0, 2));
      if (op == 2) begin
        if (m_kv) run_des(int'($urandom_range(0, 9)), 1'b1);
        else      err_probe(2);
      end else begin
        run_ecc(op == 1, int'($urandom_range(1, MAX_LAT)), rnd_w(), rnd_w(), 1'b0);
      end
    end

    // Abort a DES session part-way through its init phase.
    for (int c = 0; c < 20; c++) begin
      des_start = 1'b1; ecc_start_pub = 1'b0; ecc_start_shr = 1'b0; ecc_done = 1'b0;
      #1 chk_o("rst_pre", 6'b000000);
      nxt();
    end
    rst = 1'b1;
    des_start = 1'b0;
    m_px = '0; m_py = '0; m_key = '0; m_kv = 1'b0;
    #1 chk_o("rst_async_outputs", 6'b000000);
    chk_regs("rst_async");
    nxt();
    nxt();
    rst = 1'b0;
    for (int c = 0; c < 110; c++) begin
      #1 chk_o("rst_no_done", 6'b000000);
      nxt();
    end
    err_probe(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
